// File: rtl/hex_display_pkg.sv
// Shared definitions for the seven-segment display driver.
//   state_e      : converter FSM states
//   SEG_BLANK    : all segments off (active-high form)
//   SEG_DASH     : middle bar only (active-high form)
//   DASH_CODE    : 5-bit display code for the dash glyph; bit 4 set marks it
//                  as distinct from the sixteen hex nibbles
//   seg_encode   : display code -> active-high segments, bit order g..a
//   max_decimal  : 10^digits - 1, used for the overflow threshold
package hex_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [4:0] DASH_CODE = 5'h10;

    function automatic logic [6:0] seg_encode(input logic [4:0] code);
        logic [6:0] seg;
        if (code[4]) begin
            seg = SEG_DASH;
        end else begin
            case (code[3:0])
                4'h0: seg = 7'h3F;
                4'h1: seg = 7'h06;
                4'h2: seg = 7'h5B;
                4'h3: seg = 7'h4F;
                4'h4: seg = 7'h66;
                4'h5: seg = 7'h6D;
                4'h6: seg = 7'h7D;
                4'h7: seg = 7'h07;
                4'h8: seg = 7'h7F;
                4'h9: seg = 7'h6F;
                4'hA: seg = 7'h77;
                4'hB: seg = 7'h7C;
                4'hC: seg = 7'h39;
                4'hD: seg = 7'h5E;
                4'hE: seg = 7'h79;
                default: seg = 7'h71;
            endcase
        end
        return seg;
    endfunction

    function automatic logic [31:0] max_decimal(input int digits);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < digits; i++) r = r * 32'd10;
        return r - 32'd1;
    endfunction

endpackage

// File: rtl/hex_display_driver_seg7.sv
// Combinational single-digit segment encoder.
//   code_i  : 5-bit display code (hex nibble or DASH_CODE)
//   blank_i : force all segments off
//   seg_o   : segments g..a, polarity applied by ACTIVE_LOW
module seg7_encoder
    import hex_display_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [4:0] code_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_pos;

    assign seg_pos = blank_i ? SEG_BLANK : seg_encode(code_i);
    assign seg_o   = (ACTIVE_LOW != 0) ? ~seg_pos : seg_pos;

endmodule

// File: rtl/hex_display_driver.sv
// Seven-segment driver for DIGITS displays, hex or decimal (double dabble).
//   clock/reset        : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : load handshake
//   in_data            : value (nibbles in hex mode, binary in decimal mode)
//   in_decimal         : decimal mode select
//   blank_lz           : leading-zero blanking enable
//   blink_mask         : per-digit blink enable
//   hex_out            : segments, digit k at [7k+6:7k]
//   overflow           : decimal value did not fit in DIGITS digits
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_decimal,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  overflow
);

    localparam int DW = 4 * DIGITS;
    localparam int IW = $clog2(DW + 1);
    localparam int PW = $clog2(BLINK_DIV);
    localparam logic [DW-1:0] MAX_DEC = DW'(max_decimal(DIGITS));

    state_e                 state_q;
    logic [DIGITS-1:0][4:0] disp_q;
    logic                   ovf_q;
    logic                   blz_q;
    logic [DIGITS-1:0]      mask_q;
    // Qualifiers of an in-flight conversion; applied only when the result
    // lands so the old display is untouched while converting.
    logic                   pend_blz_q;
    logic [DIGITS-1:0]      pend_mask_q;
    logic [DW-1:0]          bin_q, bin_d;
    logic [DW-1:0]          bcd_q, bcd_d;
    logic [IW-1:0]          iter_q;
    logic [PW-1:0]          presc_q;
    logic                   phase_q;

    assign in_ready = (state_q == ST_IDLE);
    assign overflow = ovf_q;

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift the
    // combined {bcd, bin} register left by one.
    logic [DW-1:0] bcd_adj;
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[DW-2:0], bin_q[DW-1]};
        bin_d = {bin_q[DW-2:0], 1'b0};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            disp_q      <= '0;
            ovf_q       <= 1'b0;
            blz_q       <= 1'b0;
            mask_q      <= '0;
            pend_blz_q  <= 1'b0;
            pend_mask_q <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!in_decimal) begin
                            for (int k = 0; k < DIGITS; k++) disp_q[k] <= {1'b0, in_data[4*k +: 4]};
                            ovf_q  <= 1'b0;
                            blz_q  <= blank_lz;
                            mask_q <= blink_mask;
                        end else if (in_data > MAX_DEC) begin
                            for (int k = 0; k < DIGITS; k++) disp_q[k] <= DASH_CODE;
                            ovf_q  <= 1'b1;
                            blz_q  <= blank_lz;
                            mask_q <= blink_mask;
                        end else begin
                            bcd_q       <= '0;
                            bin_q       <= in_data;
                            iter_q      <= '0;
                            pend_blz_q  <= blank_lz;
                            pend_mask_q <= blink_mask;
                            state_q     <= ST_CONVERT;
                        end
                    end
                end
                ST_CONVERT: begin
                    bcd_q  <= bcd_d;
                    bin_q  <= bin_d;
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == IW'(DW - 1)) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    for (int k = 0; k < DIGITS; k++) disp_q[k] <= {1'b0, bcd_q[4*k +: 4]};
                    ovf_q   <= 1'b0;
                    blz_q   <= pend_blz_q;
                    mask_q  <= pend_mask_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Free-running blink prescaler; phase flips on each wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            phase_q <= 1'b0;
        end else if (presc_q == PW'(BLINK_DIV - 1)) begin
            presc_q <= '0;
            phase_q <= ~phase_q;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Blank zero digits from the top down until the first non-zero one.
    // Digit 0 is never considered; DASH_CODE is non-zero so it stops the run.
    logic [DIGITS-1:0] lz_blank;
    logic              lead;
    always_comb begin
        lz_blank = '0;
        lead     = blz_q;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && disp_q[k] == 5'h00) lz_blank[k] = 1'b1;
            else                            lead        = 1'b0;
        end
    end

    // Outputs depend only on registers, so hex_out is glitch-free of inputs.
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        seg7_encoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
            .code_i  (disp_q[k]),
            .blank_i (lz_blank[k] | (phase_q & mask_q[k])),
            .seg_o   (hex_out[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

    localparam int D  = 4;
    localparam int BD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4*D-1:0] in_data;
    logic          in_decimal;
    logic          blank_lz;
    logic [D-1:0]  blink_mask;
    logic [7*D-1:0] hex_out;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    hex_display_driver #(.DIGITS(D), .BLINK_DIV(BD), .ACTIVE_LOW(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_decimal(in_decimal), .blank_lz(blank_lz),
        .blink_mask(blink_mask), .hex_out(hex_out), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Active-high glyphs 0..F; dash is the middle bar only.
    logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Behavioural model: what the display shows, plus a countdown of the
    // cycles a decimal conversion keeps the block busy.
    bit          m_init = 0;
    int          m_cyc, m_busy;
    int          m_dig [D];          // -1 = dash
    bit          m_ovf, m_blz, p_blz;
    logic [D-1:0] m_mask, p_mask;
    int unsigned m_pend;

    always @(posedge clock) begin
        if (reset) begin
            m_init = 1; m_cyc = 0; m_busy = 0; m_ovf = 0; m_blz = 0; m_mask = '0;
            for (int k = 0; k < D; k++) m_dig[k] = 0;
        end else if (m_init) begin
            bit acc;
            acc = in_valid && (m_busy == 0);
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    for (int k = 0; k < D; k++) m_dig[k] = (m_pend / (10 ** k)) % 10;
                    m_ovf = 0; m_blz = p_blz; m_mask = p_mask;
                end
            end
            if (acc) begin
                if (!in_decimal) begin
                    for (int k = 0; k < D; k++) m_dig[k] = (in_data >> (4 * k)) & 15;
                    m_ovf = 0; m_blz = blank_lz; m_mask = blink_mask;
                end else if (in_data > 10 ** D - 1) begin
                    for (int k = 0; k < D; k++) m_dig[k] = -1;
                    m_ovf = 1; m_blz = blank_lz; m_mask = blink_mask;
                end else begin
                    m_busy = 4 * D + 1; m_pend = in_data; p_blz = blank_lz; p_mask = blink_mask;
                end
            end
            m_cyc++;
        end
    end

    function automatic logic [7*D-1:0] exp_hex();
        logic [7*D-1:0] r;
        bit lead, bl, phase;
        logic [6:0] seg;
        r = '0;
        lead = m_blz;
        phase = ((m_cyc / BD) % 2) == 1;
        for (int k = D - 1; k >= 0; k--) begin
            bl = 0;
            if (k > 0 && lead && m_dig[k] == 0) bl = 1;
            else lead = 0;
            if (phase && m_mask[k]) bl = 1;
            seg = bl ? 7'h00 : (m_dig[k] < 0 ? 7'h40 : GLY[m_dig[k]]);
            r[7*k +: 7] = ~seg;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clock) begin
        if (m_init) begin
            chk("hex_out", 64'(hex_out), 64'(exp_hex()));
            chk("in_ready", 64'(in_ready), 64'(m_busy == 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    task automatic load(input logic [15:0] v, input bit dec, input bit blz, input logic [3:0] mask);
        bit done;
        done = 0;
        in_data = v; in_decimal = dec; blank_lz = blz; blink_mask = mask; in_valid = 1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge clock); #1;
        end
        in_valid = 0;
        if (!done) chk("load_timeout", 64'd0, 64'd1);
    endtask

    // Counts busy cycles until in_ready, sampling at negedges.
    task automatic wait_ready(output int cnt);
        bit done;
        done = 0; cnt = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (in_ready) done = 1;
            else cnt++;
        end
        if (!done) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int cnt, b0, b1;
        reset = 1; in_valid = 0; in_data = '0; in_decimal = 0; blank_lz = 0; blink_mask = '0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_hex", 64'(hex_out), 64'({4{7'b1000000}}));
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_ovf", 64'(overflow), 64'd0);

        @(posedge clock); #1;
        load(16'hBEEF, 0, 0, 4'b0000);
        @(negedge clock);
        chk("hex_BEEF", 64'(hex_out), 64'({7'h03, 7'h06, 7'h06, 7'h0E}));
        @(posedge clock); #1;
        load(16'h0001, 0, 0, 4'b0000);
        load(16'h0002, 0, 0, 4'b0000);
        @(negedge clock);
        chk("hex_0002", 64'(hex_out), 64'({7'h40, 7'h40, 7'h40, 7'h24}));

        @(posedge clock); #1;
        load(16'd1234, 1, 0, 4'b0000);
        wait_ready(cnt);
        chk("dec_busy_cycles", 64'(cnt), 64'd17);
        chk("dec_1234", 64'(hex_out), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
        @(posedge clock); #1;
        load(16'd9999, 1, 0, 4'b0000);
        wait_ready(cnt);
        chk("dec_9999", 64'(hex_out), 64'({4{7'h10}}));
        @(posedge clock); #1;
        load(16'd10000, 1, 0, 4'b0000);
        @(negedge clock);
        chk("ovf_dash", 64'(hex_out), 64'({4{7'h3F}}));
        chk("ovf_flag", 64'(overflow), 64'd1);

        @(posedge clock); #1;
        load(16'd7, 1, 1, 4'b0000);
        wait_ready(cnt);
        chk("lz_dec7", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h78}));
        chk("lz_dec7_ovf", 64'(overflow), 64'd0);
        @(posedge clock); #1;
        load(16'h0000, 0, 1, 4'b0000);
        @(negedge clock);
        chk("lz_hex0", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        @(posedge clock); #1;
        load(16'h1234, 0, 0, 4'b0101);
        b0 = 0; b1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (hex_out[6:0] == 7'h7F) b0++;
            if (hex_out[13:7] == 7'h7F) b1++;
        end
        chk("blink_d0_blank_cycles", 64'(b0), 64'd4);
        chk("blink_d1_blank_cycles", 64'(b1), 64'd0);

        @(posedge clock); #1;
        load(16'd1234, 1, 0, 4'b0000);
        repeat (5) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        chk("midconv_reset_hex", 64'(hex_out), 64'({4{7'b1000000}}));
        chk("midconv_reset_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        load(16'd42, 1, 0, 4'b0000);
        wait_ready(cnt);
        chk("dec_0042", 64'(hex_out), 64'({7'h40, 7'h40, 7'h19, 7'h24}));

        // Random traffic, including valid held while busy and stray resets.
        @(posedge clock); #1;
        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            in_valid   = $urandom_range(0, 2) == 0;
            in_decimal = $urandom_range(0, 1);
            in_data    = in_decimal ? 16'($urandom_range(0, 11000)) : 16'($urandom);
            blank_lz   = $urandom_range(0, 1);
            blink_mask = 4'($urandom);
            @(posedge clock); #1;
        end
        reset = 0; in_valid = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
